// File: rtl/sdram_traffic_gen.sv
// sdram_traffic_gen: Avalon-MM pattern writer plus pipelined readback checker
`timescale 1ns/1ps
module sdram_traffic_gen #(
  parameter int ADDR_W   = 22,
  parameter int DATA_W   = 16,
  parameter int BE_W     = DATA_W / 8,
  parameter int MAX_PEND = 4,
  parameter int ERR_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic [DATA_W-1:0] seed,
  output logic [ADDR_W-1:0] av_addr,
  output logic [BE_W-1:0]   av_be_n,
  output logic [DATA_W-1:0] av_data,
  output logic              av_wr_n,
  output logic              av_rd_n,
  input  logic              av_waitrequest,
  input  logic [DATA_W-1:0] av_readdata,
  input  logic              av_readdatavalid,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr
);
  typedef enum logic [2:0] {IDLE, WRITE, GAP, READ, DRAIN, FIN} state_t;
  state_t state, nxt;
  logic [1:0] mode_q;
  logic [ADDR_W-1:0] base_q, len_q, wi, ri, raddr;
  logic [DATA_W-1:0] seed_q, rexp;
  logic [3:0] pending;
  logic wr_acc, rd_acc, rv, can_rd, last, mism;

  function automatic logic [DATA_W-1:0] pat(input logic [1:0] m, input logic [DATA_W-1:0] s,
                                            input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] i);
    return m == 2'd0 ? DATA_W'(a) : m == 2'd1 ? ~DATA_W'(a) : m == 2'd2 ? s : s + DATA_W'(i);
  endfunction

  assign av_be_n = '0;
  assign can_rd  = pending < 4'(MAX_PEND) || (pending == 4'(MAX_PEND) && av_readdatavalid);
  assign wr_acc  = !av_wr_n && !av_waitrequest;
  assign rd_acc  = !av_rd_n && !av_waitrequest;
  assign rv      = av_readdatavalid && (state == READ || state == DRAIN) && pending != 4'd0;
  assign last    = wi == len_q - ADDR_W'(1);
  assign raddr   = base_q + ri;
  assign rexp    = pat(mode_q, seed_q, raddr, ri);
  assign mism    = rv && av_readdata != rexp;

  // state register
  always_ff @(posedge clk)
    state <= reset ? IDLE : nxt;

  // next-state logic
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? (length == '0 ? FIN : WRITE) : IDLE;
      WRITE:   nxt = wr_acc && last ? GAP : WRITE;
      GAP:     nxt = READ;
      READ:    nxt = rd_acc && last ? DRAIN : READ;
      DRAIN:   nxt = pending == 4'd0 ? FIN : DRAIN;
      default: nxt = IDLE;
    endcase
  end

  // bus strobes and busy; reads are throttled by the outstanding-read budget
  always_comb begin
    av_wr_n = state != WRITE;
    av_rd_n = !(state == READ && can_rd);
    busy    = state inside {WRITE, GAP, READ, DRAIN};
  end

  // request address/data, outstanding-read count, checker and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= '0;
      base_q <= '0;
      len_q <= '0;
      seed_q <= '0;
      wi <= '0;
      ri <= '0;
      av_addr <= '0;
      av_data <= '0;
      pending <= '0;
      err_count <= '0;
      first_err_addr <= '0;
      done <= 1'b0;
      pass <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        mode_q <= mode;
        base_q <= base_addr;
        len_q <= length;
        seed_q <= seed;
        wi <= '0;
        ri <= '0;
        av_addr <= base_addr;
        av_data <= pat(mode, seed, base_addr, '0);
        err_count <= '0;
        first_err_addr <= '0;
        done <= 1'b0;
        pass <= 1'b0;
      end
      if (wr_acc) begin
        wi <= wi + ADDR_W'(1);
        av_addr <= av_addr + ADDR_W'(1);
        av_data <= pat(mode_q, seed_q, av_addr + ADDR_W'(1), wi + ADDR_W'(1));
      end
      if (state == GAP) begin
        wi <= '0;
        av_addr <= base_q;
      end
      if (rd_acc) begin
        wi <= wi + ADDR_W'(1);
        av_addr <= av_addr + ADDR_W'(1);
      end
      pending <= pending + 4'(rd_acc) - 4'(rv);
      if (rv) ri <= ri + ADDR_W'(1);
      if (mism) begin
        err_count <= &err_count ? err_count : err_count + ERR_W'(1);
        if (err_count == '0) first_err_addr <= raddr;
      end
      if (nxt == FIN && state != FIN) begin
        done <= 1'b1;
        pass <= state == IDLE || err_count == '0;
      end
    end
  end
endmodule

// File: tb/tb_sdram_traffic_gen.sv
// tb_sdram_traffic_gen: randomized self-checking bench with a memory slave model
`timescale 1ns/1ps
module tb_sdram_traffic_gen;
  localparam int AW = 22, DW = 16, BW = 2, MP = 4, EW = 16;
  logic clk = 0, reset = 1, start = 0;
  logic [1:0] mode = 0;
  logic [AW-1:0] base_addr = 0, length = 0;
  logic [DW-1:0] seed = 0;
  logic [AW-1:0] av_addr, first_err_addr;
  logic [BW-1:0] av_be_n;
  logic [DW-1:0] av_data;
  logic av_wr_n, av_rd_n, busy, done, pass;
  logic av_waitrequest = 0, av_readdatavalid = 0;
  logic [DW-1:0] av_readdata = 0;
  logic [EW-1:0] err_count;

  sdram_traffic_gen dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .base_addr(base_addr),
    .length(length), .seed(seed), .av_addr(av_addr), .av_be_n(av_be_n), .av_data(av_data),
    .av_wr_n(av_wr_n), .av_rd_n(av_rd_n), .av_waitrequest(av_waitrequest),
    .av_readdata(av_readdata), .av_readdatavalid(av_readdatavalid), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .first_err_addr(first_err_addr)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_ok = 0;
  task automatic chk(string tag, longint got, longint exp);
    n_chk++;
    if (got == exp) n_ok++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] ref_pat(int m, int a, int i, int s);
    logic [DW-1:0] al;
    al = DW'(a);
    case (m)
      0: return al;
      1: return ~al;
      2: return DW'(s);
      default: return DW'(s + i);
    endcase
  endfunction

  typedef struct {int t; logic [DW-1:0] d;} ret_t;
  ret_t rq[$];
  ret_t r;
  logic [DW-1:0] mem[int];
  bit corrupt[int];
  logic [AW-1:0] exp_wa[$], exp_ra[$];
  logic [DW-1:0] exp_wd[$];
  logic [AW-1:0] hold_a;
  logic [DW-1:0] hold_d, rd_d;
  int stall_n = 0, lat = 1, cyc = 0, stall_left = 0, rd_idx = 0, out_cnt = 0;
  int rd_first = -1, rd_last = -1, n_strobe = 0, last_lat = 0;
  bit in_req = 0;

  // slave: returns at negedge, then decides waitrequest and records accepted requests
  always @(negedge clk) begin
    cyc++;
    av_readdatavalid = 0;
    if (rq.size() > 0 && rq[0].t <= cyc) begin
      r = rq.pop_front();
      av_readdatavalid = 1;
      av_readdata = r.d;
      if (out_cnt > 0) out_cnt--;
    end
    #1;
    av_waitrequest = 0;
    if (!av_wr_n || !av_rd_n) begin
      n_strobe++;
      chk("excl", av_wr_n | av_rd_n, 1);
      if (!in_req) begin
        in_req = 1;
        stall_left = stall_n;
        hold_a = av_addr;
        hold_d = av_data;
      end
      if (stall_left > 0) begin
        stall_left--;
        av_waitrequest = 1;
      end else begin
        in_req = 0;
        chk("hold_addr", av_addr, hold_a);
        chk("be_n", av_be_n, 0);
        if (!av_wr_n) begin
          if (exp_wa.size() == 0) chk("extra_wr", 1, 0);
          else begin
            chk("wr_addr", av_addr, exp_wa.pop_front());
            chk("wr_data", av_data, exp_wd.pop_front());
            chk("hold_data", av_data, hold_d);
          end
          mem[int'(av_addr)] = av_data;
        end else begin
          if (exp_ra.size() == 0) chk("extra_rd", 1, 0);
          else chk("rd_addr", av_addr, exp_ra.pop_front());
          rd_d = mem.exists(int'(av_addr)) ? mem[int'(av_addr)] : '0;
          if (corrupt.exists(rd_idx)) rd_d ^= 16'h0f0f;
          rq.push_back('{cyc + lat, rd_d});
          rd_idx++;
          out_cnt++;
          chk("pend_max", out_cnt <= MP, 1);
          if (rd_first < 0) rd_first = cyc;
          rd_last = cyc;
        end
      end
    end else in_req = 0;
  end

  task automatic launch(int m, int b, int len, int s, int st, int l, int c0, int c1);
    exp_wa.delete(); exp_wd.delete(); exp_ra.delete(); corrupt.delete();
    if (c0 >= 0) corrupt[c0] = 1;
    if (c1 >= 0) corrupt[c1] = 1;
    rd_idx = 0; out_cnt = 0; rd_first = -1; rd_last = -1; n_strobe = 0;
    stall_n = st; lat = l;
    for (int i = 0; i < len; i++) begin
      int a;
      a = (b + i) % (1 << AW);
      exp_wa.push_back(AW'(a));
      exp_wd.push_back(ref_pat(m, a, i, s));
      exp_ra.push_back(AW'(a));
    end
    @(negedge clk);
    start = 1; mode = 2'(m); base_addr = AW'(b); length = AW'(len); seed = DW'(s);
    @(negedge clk);
    start = 0;
  endtask

  task automatic finish(string nm, int b, int len, int c0, int c1, bit poke, int exp_lat);
    int j, ne, fi;
    j = 0; ne = 0; fi = len;
    chk({nm, "_busy"}, busy, len > 0);
    while (!done && j < 3000) begin
      start = poke && j == 3;
      if (poke && j == 3) begin mode = ~mode; length = 5; end
      @(negedge clk);
      j++;
    end
    start = 0;
    last_lat = j + 1;
    foreach (corrupt[k]) if (k < len) begin ne++; if (k < fi) fi = k; end
    chk({nm, "_done"}, done, 1);
    chk({nm, "_idle"}, busy, 0);
    chk({nm, "_pass"}, pass, ne == 0);
    chk({nm, "_errs"}, err_count, ne);
    chk({nm, "_first"}, first_err_addr, ne > 0 ? (b + fi) % (1 << AW) : 0);
    chk({nm, "_wr_left"}, exp_wa.size(), 0);
    chk({nm, "_rd_left"}, exp_ra.size(), 0);
    if (exp_lat > 0) chk({nm, "_lat"}, last_lat, exp_lat);
    repeat (2) @(negedge clk);
    chk({nm, "_hold"}, done, 1);
  endtask

  initial begin
    int m, b, len, s, st, l, c0, c1, k;
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("rst_wr_n", av_wr_n, 1); chk("rst_rd_n", av_rd_n, 1);
    chk("rst_addr", av_addr, 0); chk("rst_data", av_data, 0); chk("rst_be", av_be_n, 0);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0); chk("rst_first", first_err_addr, 0);

    launch(0, 'h00babe, 8, 0, 3, 2, -1, -1);
    finish("wstall", 'h00babe, 8, -1, -1, 0, 0);

    launch(3, 'h001234, 16, 'hd00d, 0, 3, -1, -1);
    finish("pipe", 'h001234, 16, -1, -1, 0, 38);
    chk("pipe_b2b", rd_last - rd_first, 15);

    launch(1, 'h3ffffe, 4, 0, 0, 2, -1, -1);
    finish("wrap", 'h3ffffe, 4, -1, -1, 0, 2 * 4 + 2 + 3);

    launch(2, 'h000400, 10, 'ha5a5, 0, 2, 3, 7);
    finish("errinj", 'h000400, 10, 3, 7, 0, 0);

    launch(0, 'h000010, 0, 0, 0, 1, -1, -1);
    finish("zero", 'h000010, 0, -1, -1, 0, 0);
    chk("zero_by2", last_lat <= 2, 1);
    chk("zero_nostrobe", n_strobe, 0);

    launch(0, 'h002000, 6, 0, 1, 2, -1, -1);
    finish("poke", 'h002000, 6, -1, -1, 1, 0);

    // reset while three reads are outstanding; stale returns would be mismatches if counted
    launch(0, 'h000200, 12, 0, 0, 5, 0, 1);
    k = 0;
    #2;
    while (out_cnt != 3 && k < 500) begin @(negedge clk); #2; k++; end
    chk("mid_reach3", out_cnt, 3);
    reset = 1;
    @(negedge clk);
    #2;
    chk("mid_wr_n", av_wr_n, 1); chk("mid_rd_n", av_rd_n, 1); chk("mid_addr", av_addr, 0);
    chk("mid_data", av_data, 0); chk("mid_busy", busy, 0); chk("mid_done", done, 0);
    chk("mid_pass", pass, 0); chk("mid_err", err_count, 0); chk("mid_first", first_err_addr, 0);
    reset = 0;
    repeat (12) @(negedge clk);
    chk("stale_err", err_count, 0);
    chk("stale_done", done, 0);
    launch(3, 'h000200, 12, 'h7777, 0, 5, -1, -1);
    finish("after_rst", 'h000200, 12, -1, -1, 0, 0);

    for (int t = 0; t < 8; t++) begin
      m = $urandom_range(0, 3);
      b = t[0] ? $urandom_range((1 << AW) - 8, (1 << AW) - 1) : $urandom_range(0, (1 << AW) - 1);
      len = $urandom_range(1, 24);
      s = $urandom_range(0, 16'hffff);
      st = $urandom_range(0, 2);
      l = $urandom_range(1, 6);
      c0 = $urandom_range(0, len);
      c1 = t[1] ? -1 : $urandom_range(0, len);
      if (c1 == c0) c1 = -1;
      launch(m, b, len, s, st, l, c0 == len ? -1 : c0, c1 == len ? -1 : c1);
      finish("rand", b, len, c0 == len ? -1 : c0, c1 == len ? -1 : c1, 0,
             (st == 0 && l <= MP) ? 2 * len + l + 3 : 0);
      repeat (8) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end
endmodule
